// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared types and frame width for the transmit path
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2
    } ser_state_t;

    localparam int TX_DATA_W = 8;

endpackage

// File: rtl/tx_byte_fifo.sv
// rtl/tx_byte_fifo.sv - byte queue with occupancy count and sticky overflow flag
module tx_byte_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_wr_en,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_rd_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Full is judged on pre-edge occupancy, so a same-cycle pop never frees room for a write.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_wr_en && !w_full;
    assign w_pop   = i_pop && !w_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (i_wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/tx_byte_serializer.sv
// rtl/tx_byte_serializer.sv - buffers bytes and shifts each out MSB-first behind a start pulse
module tx_byte_serializer
    import tx_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = TX_DATA_W
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_wr_en,
    input  logic [DATA_W-1:0]          i_wr_data,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    input  logic                       i_transmit_ready,
    output logic                       o_tx_ctrl,
    output logic                       o_bit_out,
    output logic                       o_ready_signal
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    ser_state_t        r_state;
    ser_state_t        w_state_nxt;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] w_shreg_nxt;
    logic [BW-1:0]     r_bitcnt;
    logic [BW-1:0]     w_bitcnt_nxt;
    logic              r_tx_ctrl;
    logic              r_bit_out;
    logic              r_ready_signal;

    logic              w_pop;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;

    tx_byte_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_nrst     (i_nrst),
        .i_wr_en    (i_wr_en),
        .i_wr_data  (i_wr_data),
        .i_pop      (w_pop),
        .o_rd_data  (w_head),
        .o_count    (o_count),
        .o_full     (o_full),
        .o_empty    (w_empty),
        .o_overflow (o_overflow)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_shreg_nxt  = r_shreg;
        w_bitcnt_nxt = r_bitcnt;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && i_transmit_ready) begin
                    w_pop       = 1'b1;
                    w_shreg_nxt = w_head;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_bitcnt_nxt = '0;
                w_state_nxt  = SHIFT;
            end
            SHIFT: begin
                if (r_bitcnt == BW'(DATA_W - 1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_shreg_nxt  = {r_shreg[DATA_W-2:0], 1'b0};
                    w_bitcnt_nxt = r_bitcnt + BW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state they describe.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state        <= IDLE;
            r_shreg        <= '0;
            r_bitcnt       <= '0;
            r_tx_ctrl      <= 1'b0;
            r_bit_out      <= 1'b0;
            r_ready_signal <= 1'b1;
        end else begin
            r_state        <= w_state_nxt;
            r_shreg        <= w_shreg_nxt;
            r_bitcnt       <= w_bitcnt_nxt;
            r_tx_ctrl      <= (w_state_nxt == START);
            r_bit_out      <= (w_state_nxt == SHIFT) && w_shreg_nxt[DATA_W-1];
            r_ready_signal <= (w_state_nxt == IDLE);
        end
    end

    assign o_tx_ctrl      = r_tx_ctrl;
    assign o_bit_out      = r_bit_out;
    assign o_ready_signal = r_ready_signal;

endmodule

// File: tb/tb_tx_byte_serializer.sv
// tb/tb_tx_byte_serializer.sv - self-checking bench for tx_byte_serializer
module tb_tx_byte_serializer;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          tr = 1'b0;
    logic          o_full;
    logic [CW-1:0] o_count;
    logic          o_overflow;
    logic          o_tx_ctrl;
    logic          o_bit_out;
    logic          o_ready;

    tx_byte_serializer #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .i_clk            (clk),
        .i_nrst           (nrst),
        .i_wr_en          (wr_en),
        .i_wr_data        (wr_data),
        .o_full           (o_full),
        .o_count          (o_count),
        .o_overflow       (o_overflow),
        .i_transmit_ready (tr),
        .o_tx_ctrl        (o_tx_ctrl),
        .o_bit_out        (o_bit_out),
        .o_ready_signal   (o_ready)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: queue of bytes plus a frame phase (0 idle, 1 start pulse, 2..DW+1 data bits).
    logic [DW-1:0] q[$];
    bit            m_ovf;
    int            phase;
    logic [DW-1:0] cur;

    localparam logic [7:0] RESET_VEC = 8'b0100_0000;

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        phase = 0;
        cur   = '0;
    endtask

    task automatic step(input logic we, input logic [DW-1:0] d, input logic t);
        bit full_pre;
        bit start;
        wr_en    = we;
        wr_data  = d;
        tr       = t;
        full_pre = (q.size() == DEPTH);
        start    = (phase == 0) && (q.size() != 0) && t;
        if (start) begin
            cur   = q.pop_front();
            phase = 1;
        end else if (phase == DW + 1) begin
            phase = 0;
        end else if (phase != 0) begin
            phase++;
        end
        if (we) begin
            if (full_pre) m_ovf = 1'b1;
            else q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_vec();
        logic b;
        b = (phase >= 2) ? cur[DW + 1 - phase] : 1'b0;
        return {phase == 1, phase == 0, b, q.size() == DEPTH, m_ovf, CW'(q.size())};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {o_tx_ctrl, o_ready, o_bit_out, o_full, o_overflow, o_count};
    endfunction

    task automatic do_reset();
        nrst  = 1'b0;
        wr_en = 1'b0;
        tr    = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (obs_vec() !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_state got %b want %b", obs_vec(), RESET_VEC);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single_byte();
        int k = -1;
        int low = 0;
        logic [DW-1:0] got = '0;
        do_reset();
        step(1'b1, 8'hCB, 1'b1);
        for (int i = 0; i < 14; i++) begin
            step(1'b0, '0, 1'b1);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL single cyc%0d got %b want %b", i, obs_vec(), exp_vec());
            end
            if (o_tx_ctrl && k < 0) k = i;
            if (k >= 0 && i > k && i <= k + DW) got = {got[DW-2:0], o_bit_out};
            if (!o_ready) low++;
        end
        n_cmp++;
        if (got !== 8'hCB) begin
            n_fail++;
            $display("FAIL single_bits got %h want cb", got);
        end
        n_cmp++;
        if (low != 9) begin
            n_fail++;
            $display("FAIL single_ready_low got %0d want 9", low);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] got = '0;
        do_reset();
        step(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b0);
            n_cmp++;
            if ({o_count, o_ready, o_tx_ctrl} !== {3'd1, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold cyc%0d got %b want 00110", i, {o_count, o_ready, o_tx_ctrl});
            end
        end
        step(1'b0, '0, 1'b1);
        n_cmp++;
        if (o_tx_ctrl !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_start got %b want 1", o_tx_ctrl);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stall_frame cyc%0d got %b want %b", i, obs_vec(), exp_vec());
            end
            if (i < DW) got = {got[DW-2:0], o_bit_out};
        end
        n_cmp++;
        if (got !== 8'hA5) begin
            n_fail++;
            $display("FAIL stall_bits got %h want a5", got);
        end
    endtask

    task automatic test_fill_overflow();
        logic [DW-1:0] sent[$];
        logic [DW-1:0] got[$];
        int            starts[$];
        logic [DW-1:0] acc = '0;
        int            k = -100;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            if (i < DEPTH) sent.push_back(d);
            step(1'b1, d, 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL fill cyc%0d got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if ({o_count, o_full, o_overflow} !== {3'd4, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL fill_flags got %b want 10011", {o_count, o_full, o_overflow});
        end
        for (int i = 0; i < 45; i++) begin
            step(1'b0, '0, 1'b1);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL drain cyc%0d got %b want %b", i, obs_vec(), exp_vec());
            end
            if (o_tx_ctrl) begin
                starts.push_back(i);
                k = i;
            end
            if (i > k && i <= k + DW) acc = {acc[DW-2:0], o_bit_out};
            if (i == k + DW) got.push_back(acc);
        end
        n_cmp++;
        if (starts.size() != DEPTH || got.size() != DEPTH) begin
            n_fail++;
            $display("FAIL drain_frames got %0d/%0d want 4", starts.size(), got.size());
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                n_cmp++;
                if (got[j] !== sent[j]) begin
                    n_fail++;
                    $display("FAIL drain_order idx%0d got %h want %h", j, got[j], sent[j]);
                end
                if (j > 0) begin
                    n_cmp++;
                    if (starts[j] - starts[j-1] != DW + 2) begin
                        n_fail++;
                        $display("FAIL drain_period idx%0d got %0d want 10", j, starts[j] - starts[j-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0);
        step(1'b1, 8'h77, 1'b1);
        n_cmp++;
        if ({o_count, o_overflow, o_tx_ctrl} !== {3'd3, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL simul_flags got %b want 01111", {o_count, o_overflow, o_tx_ctrl});
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b0, '0, 1'b1);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL simul_drain cyc%0d got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [DW-1:0] got = '0;
        int k = -100;
        do_reset();
        step(1'b1, 8'hFF, 1'b1);
        step(1'b1, 8'h11, 1'b1);
        step(1'b1, 8'h22, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL midframe_pre got %b want %b", obs_vec(), exp_vec());
        end
        #2;
        nrst = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (obs_vec() !== RESET_VEC) begin
            n_fail++;
            $display("FAIL midframe_reset got %b want %b", obs_vec(), RESET_VEC);
        end
        @(posedge clk);
        #1;
        nrst = 1'b1;
        step(1'b1, 8'h01, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b1);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL post_reset cyc%0d got %b want %b", i, obs_vec(), exp_vec());
            end
            if (o_tx_ctrl) k = i;
            if (i > k && i <= k + DW) got = {got[DW-2:0], o_bit_out};
        end
        n_cmp++;
        if (got !== 8'h01) begin
            n_fail++;
            $display("FAIL post_reset_bits got %h want 01", got);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 5, DW'($urandom), $urandom_range(0, 9) < 6);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc%0d got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_stall();
        test_fill_overflow();
        test_simultaneous();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
